// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell is reused LSB->MSB with a registered carry.
// Operands come in over a valid/ready handshake and {c_out, sum} leave over a second one.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_in_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_out_o,
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  opa_q, opb_q, res_q, res_d, sum_q;
  logic              carry_q, c_out_q;
  logic [CntW-1:0]   cnt_q;
  logic              fa_a, fa_b, fa_sum, fa_cout;
  logic              last_bit;

  // Shared full-adder cell.
  assign fa_a    = opa_q[0];
  assign fa_b    = opb_q[0];
  assign fa_sum  = fa_a ^ fa_b ^ carry_q;
  assign fa_cout = (fa_a & fa_b) | (carry_q & (fa_a ^ fa_b));

  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_d = fa_sum;
    end else begin : g_res_wn
      assign res_d = {fa_sum, res_q[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            opa_q   <= a_i;
            opb_q   <= b_i;
            carry_q <= c_in_i;
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          opa_q   <= opa_q >> 1;
          opb_q   <= opb_q >> 1;
          res_q   <= res_d;
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + CntW'(1);
          if (last_bit) begin
            sum_q   <= res_d;
            c_out_q <= fa_cout;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q == StRun) || (state_q == StDone);
  assign sum_o       = sum_q;
  assign c_out_o     = c_out_q;

endmodule
